// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then an opcode-dependent execute sequence.
// Optional immediate ops (addi/andi/ori) are enabled by defining CU_IMM_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        Read,
  output logic        IncPC,
  output logic [4:0]  operation,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Run
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_ALU3   = 3'd1;
  localparam logic [2:0] C_MULDIV = 3'd2;
  localparam logic [2:0] C_UNARY  = 3'd3;
  localparam logic [2:0] C_IMM    = 3'd4;
  localparam logic [2:0] C_HALT   = 3'd5;

  logic [3:0] state_reg, state_next;
  logic [4:0] opcode_reg;
  logic [2:0] ir_class, op_class;

  // Register fields are decoded by the datapath's select-and-encode logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  function automatic logic [2:0] classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: classify = C_ALU3;
      5'b01110, 5'b01111:                     classify = C_MULDIV;
      5'b10000, 5'b10001:                     classify = C_UNARY;
`ifdef CU_IMM_EN
      5'b01011, 5'b01100, 5'b01101:           classify = C_IMM;
`endif
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_NONE;
    endcase
  endfunction

`ifdef CU_IMM_EN
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      5'b01100: imm_alu_op = 5'b01001;
      5'b01101: imm_alu_op = 5'b01010;
      default:  imm_alu_op = 5'b00011;
    endcase
  endfunction
`endif

  assign ir_class = classify(IR[31:27]);
  assign op_class = classify(opcode_reg);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= S_RST;
      opcode_reg <= 5'b00000;
    end else begin
      state_reg <= state_next;
      // Opcode is captured only on leaving T2; IR is ignored at every other edge.
      if (state_reg == S_T2) opcode_reg <= IR[31:27];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST: state_next = S_T0;
      S_T0:  state_next = S_T1;
      S_T1:  state_next = S_T2;
      S_T2: begin
        if (ir_class == C_HALT)      state_next = S_HALT;
        else if (ir_class == C_NONE) state_next = S_T0;
        else                         state_next = S_T3;
      end
      S_T3:  state_next = S_T4;
      S_T4:  state_next = (op_class == C_UNARY) ? S_T0 : S_T5;
      S_T5:  state_next = (op_class == C_MULDIV) ? S_T6 : S_T0;
      S_T6:  state_next = S_T0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  assign HIout = 1'b0;
  assign LOout = 1'b0;
  assign Run   = (state_reg != S_RST) && (state_reg != S_HALT);

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ZHIin = 1'b0; ZLOin = 1'b0;
    Read = 1'b0; IncPC = 1'b0; operation = 5'b00000;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    case (state_reg)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        if (op_class == C_UNARY) begin
          operation = opcode_reg;
          ZLOin     = 1'b1;
        end else begin
          Yin = 1'b1;
        end
      end
      S_T4: begin
        case (op_class)
          C_ALU3: begin
            Grc = 1'b1; Rout = 1'b1; operation = opcode_reg; ZLOin = 1'b1;
          end
          C_MULDIV: begin
            Grc = 1'b1; Rout = 1'b1; operation = opcode_reg; ZHIin = 1'b1; ZLOin = 1'b1;
          end
          C_UNARY: begin
            ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
`ifdef CU_IMM_EN
          C_IMM: begin
            Cout = 1'b1; operation = imm_alu_op(opcode_reg); ZLOin = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (op_class == C_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: one row per clock cycle,
// plus hand-written sequences for halt recovery and asynchronous abort.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR  = 32'h0;
  logic PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin;
  logic Read, IncPC, Gra, Grb, Grc, Rin, Rout, Run;
  logic [4:0] operation;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin),
    .Read(Read), .IncPC(IncPC), .operation(operation),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Run(Run)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] RUN  = 24'h800000, PCO  = 24'h400000, ZHO  = 24'h200000;
  localparam logic [23:0] ZLO  = 24'h100000, HIO  = 24'h080000, LOO  = 24'h040000;
  localparam logic [23:0] MDRO = 24'h020000, CO   = 24'h010000, MARI = 24'h008000;
  localparam logic [23:0] PCI  = 24'h004000, MDRI = 24'h002000, IRI  = 24'h001000;
  localparam logic [23:0] YI   = 24'h000800, HII  = 24'h000400, LOI  = 24'h000200;
  localparam logic [23:0] ZHII = 24'h000100, ZLOI = 24'h000080, RD   = 24'h000040;
  localparam logic [23:0] INC  = 24'h000020, GRA  = 24'h000010, GRB  = 24'h000008;
  localparam logic [23:0] GRC  = 24'h000004, RIN  = 24'h000002, ROUT = 24'h000001;

  localparam logic [23:0] S_T0 = RUN | PCO | MARI | INC | ZLOI;
  localparam logic [23:0] S_T1 = RUN | ZLO | PCI | RD | MDRI;
  localparam logic [23:0] S_T2 = RUN | MDRO | IRI;
  localparam logic [23:0] S_T3Y = RUN | GRB | ROUT | YI;
  localparam logic [23:0] S_T4R = RUN | GRC | ROUT | ZLOI;
  localparam logic [23:0] S_WB  = RUN | ZLO | GRA | RIN;

  // Fetch-time IR holds a halt opcode: it must never be acted on outside the T2 edge.
  localparam logic [31:0] GARB = 32'hD8000000;

  logic [23:0] strobes;
  assign strobes = {Run, PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout,
                    MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin,
                    Read, IncPC, Gra, Grb, Grc, Rin, Rout};

  typedef struct {
    logic [31:0] ir;
    logic [23:0] exp_s;
    logic [4:0]  exp_op;
    string       name;
  } row_t;

  row_t rows[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bool_t_dummy_unused_guard guard_unused();

  task automatic push(input logic [31:0] ir, input logic [23:0] s, input logic [4:0] op,
                      input string name);
    row_t r;
    r.ir = ir; r.exp_s = s; r.exp_op = op; r.name = name;
    rows.push_back(r);
  endtask

  task automatic fetch12();
    push(GARB, S_T1, 5'b0, "T1");
    push(GARB, S_T2, 5'b0, "T2");
  endtask

  task automatic check(input string name, input logic [23:0] s, input logic [4:0] op);
    n_cmp++;
    if (strobes !== s || operation !== op) begin
      n_bad++;
      $display("FAIL %s: strobes=%06h op=%05b, required strobes=%06h op=%05b",
               name, strobes, operation, s, op);
    end else begin
      $display("ok   %s: strobes=%06h op=%05b", name, strobes, operation);
    end
  endtask

  // No two bus drivers may be active in the same cycle.
  always @(negedge clk) begin
    n_cmp++;
    assert ($countones({PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout, Rout}) <= 1)
    else begin
      n_bad++;
      $display("FAIL bus_exclusive: drivers=%08b at %0t, required at most one",
               {PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout, Rout}, $time);
    end
  end

  initial begin
    push(GARB, S_T0, 5'b0, "first_T0");
    fetch12();
    push(32'h4A920000, S_T3Y, 5'b0, "and_T3");
    push(GARB, S_T4R, 5'b01001, "and_T4");
    push(GARB, S_WB, 5'b0, "and_T5");
    push(GARB, S_T0, 5'b0, "and_T0_after6");
    fetch12();
    push(32'h7A920000, S_T3Y, 5'b0, "div_T3");
    push(GARB, S_T4R | ZHII, 5'b01111, "div_T4");
    push(GARB, RUN | ZLO | LOI, 5'b0, "div_T5");
    push(GARB, RUN | ZHO | HII, 5'b0, "div_T6");
    push(GARB, S_T0, 5'b0, "div_T0_after7");
    fetch12();
    push(32'h8A900000, RUN | GRB | ROUT | ZLOI, 5'b10001, "not_T3");
    push(GARB, S_WB, 5'b0, "not_T4");
    push(GARB, S_T0, 5'b0, "not_T0_after5");
    fetch12();
    push(32'hD0000000, S_T0, 5'b0, "nop_T0_after3");
    fetch12();
`ifdef CU_IMM_EN
    push(32'h58000000, S_T3Y, 5'b0, "addi_T3");
    push(GARB, RUN | CO | ZLOI, 5'b00011, "addi_T4");
    push(GARB, S_WB, 5'b0, "addi_T5");
    push(GARB, S_T0, 5'b0, "addi_T0_after6");
`else
    push(32'h58000000, S_T0, 5'b0, "addi_undef_T0");
`endif
    fetch12();
    push(32'hF8000000, S_T0, 5'b0, "undef_T0_after3");
    fetch12();
    push(32'h30000000, S_T3Y, 5'b0, "shl_T3");
    push(GARB, S_T4R, 5'b00110, "shl_T4");
    push(GARB, S_WB, 5'b0, "shl_T5");
    push(GARB, S_T0, 5'b0, "shl_T0");
    fetch12();
    push(32'h70000000, S_T3Y, 5'b0, "mul_T3");
    push(GARB, S_T4R | ZHII, 5'b01110, "mul_T4");
    push(GARB, RUN | ZLO | LOI, 5'b0, "mul_T5");
    push(GARB, RUN | ZHO | HII, 5'b0, "mul_T6");
    push(GARB, S_T0, 5'b0, "mul_T0");
    fetch12();
    push(32'hD8000000, 24'h0, 5'b0, "halt_entry");
    for (int i = 0; i < 20; i++) push(32'h4A920000, 24'h0, 5'b0, "halt_hold");

    // Reset: everything low while clr is held.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", 24'h0, 5'b0);
    end
    clr = 1'b0;

    foreach (rows[i]) begin
      IR = rows[i].ir;
      @(posedge clk);
      @(negedge clk);
      check(rows[i].name, rows[i].exp_s, rows[i].exp_op);
    end

    // A clr pulse is the only way out of HALT.
    clr = 1'b1;
    #1 check("clr_in_halt", 24'h0, 5'b0);
    @(negedge clk);
    clr = 1'b0;
    IR = GARB;
    @(posedge clk); @(negedge clk);
    check("restart_from_halt_T0", S_T0, 5'b0);
    @(posedge clk); @(negedge clk);
    check("restart_T1", S_T1, 5'b0);
    @(posedge clk); @(negedge clk);
    check("restart_T2", S_T2, 5'b0);
    IR = 32'h18000000;
    @(posedge clk); @(negedge clk);
    check("add_T3", S_T3Y, 5'b0);
    IR = GARB;
    @(posedge clk); @(negedge clk);
    check("add_T4", S_T4R, 5'b00011);

    // Abort mid-T4 between clock edges: outputs must fall without any edge.
    #2 clr = 1'b1;
    #1 check("async_abort", 24'h0, 5'b0);
    @(negedge clk);
    check("abort_held", 24'h0, 5'b0);
    clr = 1'b0;
    @(posedge clk); @(negedge clk);
    check("after_abort_T0_not_T5", S_T0, 5'b0);
    @(posedge clk); @(negedge clk);
    check("after_abort_T1", S_T1, 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

module bool_t_dummy_unused_guard;
endmodule
